// File: rtl/seg7_scan_driver_if.sv
// Load-side bus of seg7_scan_driver: display data, per-digit controls, load strobe
// and the pending status returned by the driver.
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en_in;
  logic                  load;
  logic                  pending;

  modport master (
    output value_in, dp_in, digit_en_in, load,
    input  pending
  );

  modport slave (
    input  value_in, dp_in, digit_en_in, load,
    output pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with frame-synchronous double buffering.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module seg7_scan_driver #(
  parameter int N_DIGITS  = 8,
  parameter int COUNT_MAX = 100000
) (
  input  logic                clock,
  input  logic                reset,
  seg7_scan_driver_if.slave   load_bus,
  output logic [6:0]          segments,
  output logic                dp,
  output logic [N_DIGITS-1:0] anodes,
  output logic                digit_tick
);
  localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  digit_tick_q, digit_tick_d;
  logic                  pending_q, pending_d;
  logic [4*N_DIGITS-1:0] stg_value_q, stg_value_d, shd_value_q, shd_value_d;
  logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic [N_DIGITS-1:0]   stg_en_q, stg_en_d, shd_en_q, shd_en_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;

  logic                  tick, frame;
  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            nib;
  logic                  nib_dp, nib_dark;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tick         = (cnt_q == CNT_W'(COUNT_MAX - 1));
    frame        = tick && (idx_q == IDX_W'(N_DIGITS - 1));
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (tick) idx_d = frame ? '0 : idx_q + 1'b1;
    digit_tick_d = tick;

    stg_value_d = stg_value_q;
    stg_dp_d    = stg_dp_q;
    stg_en_d    = stg_en_q;
    shd_value_d = shd_value_q;
    shd_dp_d    = shd_dp_q;
    shd_en_d    = shd_en_q;
    pending_d   = pending_q;

    if (load_bus.load) begin
      stg_value_d = load_bus.value_in;
      stg_dp_d    = load_bus.dp_in;
      stg_en_d    = load_bus.digit_en_in;
      pending_d   = 1'b1;
    end
    // A load landing on the boundary edge bypasses staging straight into the shadow.
    if (frame) begin
      if (load_bus.load) begin
        shd_value_d = load_bus.value_in;
        shd_dp_d    = load_bus.dp_in;
        shd_en_d    = load_bus.digit_en_in;
      end else if (pending_q) begin
        shd_value_d = stg_value_q;
        shd_dp_d    = stg_dp_q;
        shd_en_d    = stg_en_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
        zero_above = zero_above && (shd_value_q[4*k +: 4] == 4'h0);
        blank[k]   = (k != 0) && zero_above && !shd_dp_q[k];
      end
    end
`endif

    nib      = 4'h0;
    nib_dp   = 1'b0;
    nib_dark = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib      = shd_value_q[4*k +: 4];
        nib_dp   = shd_dp_q[k];
        nib_dark = !shd_en_q[k] || blank[k];
      end
    end

    anodes_d   = '1;
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (!nib_dark) begin
      anodes_d[idx_q] = 1'b0;
      segments_d      = hex_decode(nib);
      dp_d            = !nib_dp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      digit_tick_q <= 1'b0;
      pending_q    <= 1'b0;
      stg_value_q  <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      shd_value_q  <= '0;
      shd_dp_q     <= '0;
      shd_en_q     <= '0;
      segments_q   <= 7'h7F;
      dp_q         <= 1'b1;
      anodes_q     <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      digit_tick_q <= digit_tick_d;
      pending_q    <= pending_d;
      stg_value_q  <= stg_value_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      shd_value_q  <= shd_value_d;
      shd_dp_q     <= shd_dp_d;
      shd_en_q     <= shd_en_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      anodes_q     <= anodes_d;
    end
  end

  assign segments         = segments_q;
  assign dp               = dp_q;
  assign anodes           = anodes_q;
  assign digit_tick       = digit_tick_q;
  assign load_bus.pending = pending_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=8, COUNT_MAX=4; cycle numbers in
// comments count rising edges since the last reset release.
module tb_seg7_scan_driver;
  localparam int N  = 8;
  localparam int CM = 4;

  logic         clock;
  logic         reset;
  logic [6:0]   segments;
  logic         dp;
  logic [N-1:0] anodes;
  logic         digit_tick;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

  seg7_scan_driver #(.N_DIGITS(N), .COUNT_MAX(CM)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_bus   (bus.slave),
    .segments   (segments),
    .dp         (dp),
    .anodes     (anodes),
    .digit_tick (digit_tick)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpv);
    bus.value_in    = v;
    bus.digit_en_in = en;
    bus.dp_in       = dpv;
    bus.load        = 1'b1;
    step(1);
    bus.load        = 1'b0;
  endtask

  initial begin
    int viol;
    bus.value_in    = '0;
    bus.digit_en_in = '0;
    bus.dp_in       = '0;
    bus.load        = 1'b0;
    reset           = 1'b1;

    // Reset asserted before the first clock edge.
    #3 reset = 1'b0;
    #1;
    check("rst_anodes", 32'(anodes), 32'hFF);
    check("rst_seg", 32'(segments), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_tick", 32'(digit_tick), 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    step(2);
    reset = 1'b1;

    // Basic scan: boundary at edge 32.
    do_load(32'h12345678, 8'hFF, 8'h00);              // e=1
    check("pend_set", 32'(bus.pending), 32'h1);
    check("dark_before", 32'(anodes), 32'hFF);
    step(30);                                          // e=31
    check("pend_hold", 32'(bus.pending), 32'h1);
    step(1);                                           // e=32
    check("pend_clear", 32'(bus.pending), 32'h0);
    check("tick_32", 32'(digit_tick), 32'h1);
    check("dark_32", 32'(anodes), 32'hFF);
    step(1);                                           // e=33
    check("d0_anodes", 32'(anodes), 32'hFE);
    check("d0_seg8", 32'(segments), 32'h00);
    check("d0_dp", 32'(dp), 32'h1);
    check("tick_low", 32'(digit_tick), 32'h0);
    step(3);                                           // e=36
    check("tick_36", 32'(digit_tick), 32'h1);
    check("d0_still", 32'(anodes), 32'hFE);
    step(1);                                           // e=37
    check("d1_anodes", 32'(anodes), 32'hFD);
    check("d1_seg7", 32'(segments), 32'h78);

    // Double buffering: load while idx=3 (edges 44..47).
    step(7);                                           // e=44
    do_load(32'hAAAAAAAA, 8'hFF, 8'h00);              // e=45
    check("db_pend", 32'(bus.pending), 32'h1);
    check("db_d3_an", 32'(anodes), 32'hF7);
    check("db_d3_old5", 32'(segments), 32'h12);
    step(16);                                          // e=61
    check("db_d7_an", 32'(anodes), 32'h7F);
    check("db_d7_old1", 32'(segments), 32'h79);
    step(2);                                           // e=63
    check("db_pend_hold", 32'(bus.pending), 32'h1);
    step(1);                                           // e=64
    check("db_pend_clr", 32'(bus.pending), 32'h0);
    step(1);                                           // e=65
    check("db_d0_an", 32'(anodes), 32'hFE);
    check("db_d0_A", 32'(segments), 32'h08);
    step(4);                                           // e=69
    check("db_d1_an", 32'(anodes), 32'hFD);
    check("db_d1_A", 32'(segments), 32'h08);

    // Masking and decimal point: boundary at edge 96.
    do_load(32'h12345678, 8'h0F, 8'h02);              // e=70
    step(27);                                          // e=97
    check("mk_d0_an", 32'(anodes), 32'hFE);
    check("mk_d0_dp", 32'(dp), 32'h1);
    step(4);                                           // e=101
    check("mk_d1_an", 32'(anodes), 32'hFD);
    check("mk_d1_seg", 32'(segments), 32'h78);
    check("mk_d1_dp", 32'(dp), 32'h0);
    step(12);                                          // e=113
    check("mk_d4_an", 32'(anodes), 32'hFF);
    check("mk_d4_seg", 32'(segments), 32'h7F);
    check("mk_d4_dp", 32'(dp), 32'h1);
    viol = 0;
    for (int i = 0; i < 32; i++) begin                 // e=114..145
      step(1);
      if (anodes[7:4] != 4'hF) viol++;
      if ((dp == 1'b0) != (anodes == 8'hFD)) viol++;
    end
    check("mk_frame_viol", 32'(viol), 32'h0);

    // Reset mid-scan at idx=5 (edges 148..151) with a load pending.
    do_load(32'h12345678, 8'hFF, 8'h00);              // e=146
    step(2);                                           // e=148
    check("mr_pend_pre", 32'(bus.pending), 32'h1);
    check("mr_tick_pre", 32'(digit_tick), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mr_tick", 32'(digit_tick), 32'h0);
    check("mr_pend", 32'(bus.pending), 32'h0);
    check("mr_anodes", 32'(anodes), 32'hFF);
    check("mr_seg", 32'(segments), 32'h7F);
    check("mr_dp", 32'(dp), 32'h1);
    @(negedge clock);
    reset = 1'b1;                                      // e=0
    step(3);                                           // e=3
    check("mr_tick_3", 32'(digit_tick), 32'h0);
    step(1);                                           // e=4
    check("mr_tick_4", 32'(digit_tick), 32'h1);
    viol = 0;
    for (int i = 0; i < 29; i++) begin                 // e=5..33
      step(1);
      if (anodes != 8'hFF || segments != 7'h7F || dp != 1'b1) viol++;
    end
    check("mr_dark_frame", 32'(viol), 32'h0);

    // Leading zeros: boundary at edge 64.
    do_load(32'h000000A0, 8'hFF, 8'h00);              // e=34
    check("lz_pend", 32'(bus.pending), 32'h1);
    step(31);                                          // e=65
    check("lz_d0_an", 32'(anodes), 32'hFE);
    check("lz_d0_seg", 32'(segments), 32'h40);
    step(4);                                           // e=69
    check("lz_d1_an", 32'(anodes), 32'hFD);
    check("lz_d1_seg", 32'(segments), 32'h08);
    step(4);                                           // e=73
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d2_an", 32'(anodes), 32'hFF);
    check("lz_d2_seg", 32'(segments), 32'h7F);
`else
    check("lz_d2_an", 32'(anodes), 32'hFB);
    check("lz_d2_seg", 32'(segments), 32'h40);
`endif
    step(20);                                          // e=93
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d7_an", 32'(anodes), 32'hFF);
    check("lz_d7_seg", 32'(segments), 32'h7F);
`else
    check("lz_d7_an", 32'(anodes), 32'h7F);
    check("lz_d7_seg", 32'(segments), 32'h40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the board's common-anode display bank. It time-multiplexes N_DIGITS hexadecimal digits with per-digit enable and decimal-point control. New values are double-buffered so they reach the display only at a frame boundary, which prevents mixed-frame tearing. It sits between the datapath result registers and the board's segment and anode pins, and it replaces the fixed 8-digit driver.

## Interface
- N_DIGITS, 8, number of digits scanned; legal range 1..16.
- COUNT_MAX, 100000, clock cycles each digit stays lit; minimum 2.
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- value_in  in  4*N_DIGITS  hex nibbles; nibble k drives digit k, and digit 0 is rightmost.
- dp_in  in  N_DIGITS  decimal-point request per digit; 1 = lit.
- digit_en_in  in  N_DIGITS  per-digit enable; 0 = digit dark.
- load  in  1  one-cycle strobe that captures value_in, dp_in and digit_en_in.
- segments  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- anodes  out  N_DIGITS  digit select, active-low, at most one low at a time.
- digit_tick  out  1  one-cycle pulse whenever the scan index advances.
- pending  out  1  a captured load is waiting for the frame boundary.

## Operation
- Refresh counter `cnt` counts 0..COUNT_MAX-1 and wraps. The wrap edge is the "tick".
- On each tick, scan index `idx` advances. It wraps from N_DIGITS-1 to 0; that wrap edge is the "frame boundary".
- Staging register: captures the inputs on any edge with load=1 and sets pending=1.
- Shadow register: on the frame boundary, if pending=1, staging is copied to shadow and pending clears.
- If load=1 on the frame-boundary edge, the shadow takes value_in directly and pending stays 0.
- A second load before the boundary overwrites staging. Only the last load is kept.
- The output stage is registered every cycle from (idx, shadow):
  - anodes has bit idx low only if shadow enable[idx]=1 and the digit is not blanked; otherwise it is all ones.
  - segments carries the hex decode of nibble idx: 0=1000000, 1=1111001, 7=1111000, 8=0000000, A=0001000, F=0001110, with the other digits following the standard table.
  - dp = ~shadow dp[idx].
  - A dark digit drives segments=7'h7F and dp=1.
- Reset values: cnt=0, idx=0, staging=0, shadow=0 (all digits disabled), pending=0, digit_tick=0, anodes=all ones, segments=7'h7F, dp=1.
- After reset the display stays dark until the first load reaches the shadow.

## Timing
- The tick occurs every COUNT_MAX cycles.
- digit_tick is registered and high for exactly the cycle after the tick edge, aligned with the new idx value.
- Outputs show digit idx one cycle after idx changes. Latency from an idx change to the anode change is 1 clock.
- Latency from the load edge to the display is (cycles to the next frame boundary) + 1, bounded by N_DIGITS*COUNT_MAX + 1.
- Reset assertion forces all outputs to their reset values asynchronously, with no clock needed. This holds mid-frame and mid-digit.
- Release of reset is synchronous to the next clock edge. Counting restarts at cnt=0, idx=0.
- With N_DIGITS=1, idx is fixed at 0, every tick is a frame boundary, and anodes[0] is low whenever that digit is enabled.

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit k ≥ 1 whose nibble and all higher nibbles in the shadow are 0 is blanked (dark) unless its dp bit is set. Digit 0 is never blanked by this rule.
- Undefined: every enabled digit is shown, including leading zeros.

## Test plan
Bench runs with N_DIGITS=8 and COUNT_MAX=4.
- Reset: hold reset=0 -> anodes=8'hFF, segments=7'h7F, dp=1, digit_tick=0, pending=0, all asserted without a clock edge.
- Basic scan: load 32'h12345678 with digit_en_in=8'hFF -> pending=1 until the boundary. Then anodes=8'hFE with segments=0000000 ('8'); 4 cycles later anodes=8'hFD with segments=1111000 ('7'). digit_tick pulses every 4 cycles.
- Double buffering: with 32'h12345678 shown, load 32'hAAAAAAAA at idx=3 -> digits 3..7 still show the old values. From the next idx=0 onward every digit shows 0001000, and pending falls at the boundary.
- Masking and dp: load with digit_en_in=8'h0F and dp_in=8'h02 -> anodes bits 7..4 never go low, and dp=0 only while anodes=8'hFD.
- Reset mid-scan: pull reset low for 1 cycle at idx=5 -> outputs go to reset values immediately. After release, idx restarts at 0 and the display stays dark until a new load.
- Macro: load 32'h000000A0 with digit_en_in=8'hFF.
  - With LEADING_ZERO_BLANK_EN: only digits 0 ('0') and 1 ('A') light.
  - Without it: all 8 digits light, digits 7..2 and 0 showing 1000000.
